// File: rtl/period_meter_pkg.sv
// period_meter_pkg: FSM state encoding and default parameters shared by period_meter files
package period_meter_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_MEASURE = 1'b1} state_t;
    localparam int DEF_CNT_WIDTH   = 20;
    localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// sync_edge_detect: synchronizes an asynchronous pin and flags its rising edge
//   CLOCK, RESET : clock, asynchronous active-high reset
//   D            : asynchronous input
//   LVL          : synchronized level
//   RISE         : synchronized level high while the history flop is still low
module sync_edge_detect import period_meter_pkg::*; #(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic D,
    output logic LVL,
    output logic RISE
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], D};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end
    assign LVL  = r_sync[SYNC_STAGES-1];
    assign RISE = r_sync[SYNC_STAGES-1] & ~r_hist;
endmodule

// File: rtl/period_meter.sv
// period_meter: counts CLOCK cycles per period and high phase of an asynchronous pin
//   CLOCK, RESET : clock, asynchronous active-high reset
//   SIG_IN       : asynchronous input waveform
//   PERIOD       : cycles between the last two rising edges
//   HIGH_TIME    : cycles SIG_IN was high within that period
//   VALID        : one-cycle strobe when PERIOD/HIGH_TIME update
//   TIMEOUT      : sticky until next capture, set when the period counter saturates
//   ACTIVE       : high while measuring
module period_meter import period_meter_pkg::*; #(
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 SIG_IN,
    output logic [CNT_WIDTH-1:0] PERIOD,
    output logic [CNT_WIDTH-1:0] HIGH_TIME,
    output logic                 VALID,
    output logic                 TIMEOUT,
    output logic                 ACTIVE
);
    localparam logic [CNT_WIDTH-1:0] MAX = '1;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    logic                 w_lvl, w_rise, w_capture, w_timeout_evt;
    logic [CNT_WIDTH-1:0] r_cnt, r_hcnt, r_period, r_high;
    logic                 r_valid, r_timeout;
    state_t               r_state, w_state_nxt;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .D    (SIG_IN),
        .LVL  (w_lvl),
        .RISE (w_rise)
    );

    // Counters restart at 1 because the edge cycle itself belongs to the new period
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else begin
            r_cnt  <= w_rise ? ONE : (r_cnt == MAX) ? r_cnt : r_cnt + ONE;
            r_hcnt <= w_rise ? ONE : (w_lvl && r_hcnt != MAX) ? r_hcnt + ONE : r_hcnt;
        end
    end

    // An edge on the saturation cycle still captures; timeout only without an edge
    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_timeout_evt = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_rise) w_state_nxt = ST_MEASURE;
        end else if (w_rise) begin
            w_capture = 1'b1;
        end else if (r_cnt == MAX) begin
            w_timeout_evt = 1'b1;
            w_state_nxt   = ST_IDLE;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_capture;
            if (w_capture) begin
                r_period  <= r_cnt;
                r_high    <= r_hcnt;
                r_timeout <= 1'b0;
            end else if (w_timeout_evt) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign PERIOD    = r_period;
    assign HIGH_TIME = r_high;
    assign VALID     = r_valid;
    assign TIMEOUT   = r_timeout;
    assign ACTIVE    = (r_state == ST_MEASURE);
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: random and directed pin waveforms checked against a cycle-count model
module tb_period_meter;
    localparam int CW  = 8;
    localparam int S   = 2;
    localparam int MAX = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sig = 1'b0;
    logic [CW-1:0] period, high_time;
    logic          valid, timeout, active;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int got_period = 0;
    int got_high   = 0;

    period_meter #(.CNT_WIDTH(CW), .SYNC_STAGES(S)) dut (
        .CLOCK    (clk),
        .RESET    (rst),
        .SIG_IN   (sig),
        .PERIOD   (period),
        .HIGH_TIME(high_time),
        .VALID    (valid),
        .TIMEOUT  (timeout),
        .ACTIVE   (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: absolute cycle numbers of rising edges seen by the synchronized pin
    int  cyc = 0, last_rise = 0, high_sum = 0;
    bit  armed = 0, m_rise = 0, m_lvl = 0;
    bit  pq[$];
    int  e_period = 0, e_high = 0;
    bit  e_valid = 0, e_timeout = 0;

    task automatic model_step();
        if (rst) begin
            cyc = 0; last_rise = 0; high_sum = 0; armed = 0; m_rise = 0; m_lvl = 0;
            pq = {};
            for (int i = 0; i <= S; i++) pq.push_front(1'b0);
            e_period = 0; e_high = 0; e_valid = 0; e_timeout = 0;
        end else begin
            e_valid = 0;
            if (m_rise) begin
                if (armed) begin
                    e_period  = cyc - last_rise;
                    e_high    = high_sum > MAX ? MAX : high_sum;
                    e_valid   = 1;
                    e_timeout = 0;
                end
                armed = 1; last_rise = cyc; high_sum = 1;
            end else begin
                if (armed && cyc - last_rise == MAX) begin
                    e_timeout = 1;
                    armed     = 0;
                end
                high_sum += int'(m_lvl);
            end
            cyc++;
            pq.push_front(sig);
            void'(pq.pop_back());
            m_lvl  = pq[S-1];
            m_rise = pq[S-1] && !pq[S];
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("valid", int'(valid), int'(e_valid));
            check("period", int'(period), e_period);
            check("high_time", int'(high_time), e_high);
            check("timeout", int'(timeout), int'(e_timeout));
            check("active", int'(active), int'(armed));
            if (valid) begin
                n_valid++;
                got_period = period;
                got_high   = high_time;
            end
        end
    end

    task automatic wave(input int hi, input int lo);
        sig = 1'b1;
        repeat (hi) @(negedge clk);
        sig = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        repeat (6) begin
            @(negedge clk);
            sig = ~sig;
            check("rst_hold_valid", int'(valid), 0);
            check("rst_hold_active", int'(active), 0);
            check("rst_hold_period", int'(period), 0);
        end
        @(negedge clk);
        sig = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);

        n_valid = 0;
        repeat (6) wave(40, 60);
        check("sq_captures", n_valid, 5);
        check("sq_period", got_period, 100);
        check("sq_high", got_high, 40);

        wave(40, 30);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_period", int'(period), 0);
        check("async_high", int'(high_time), 0);
        check("async_active", int'(active), 0);
        check("async_valid", int'(valid), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        n_valid = 0;
        sig = 1'b1;
        for (int k = 1; k <= 262; k++) begin
            @(negedge clk);
            if (k == 1) sig = 1'b0;
            if (k == 257) begin
                check("to_before_timeout", int'(timeout), 0);
                check("to_before_active", int'(active), 1);
            end
            if (k == 258) begin
                check("to_at_timeout", int'(timeout), 1);
                check("to_at_active", int'(active), 0);
            end
        end
        check("to_no_valid", n_valid, 0);
        check("to_period_held", int'(period), 0);

        wave(5, 45);
        wave(5, 45);
        check("after_to_captures", n_valid, 1);
        check("after_to_period", got_period, 50);
        check("after_to_timeout", int'(timeout), 0);

        wave(5, 250);
        wave(5, 250);
        check("bnd_255_period", got_period, 255);
        check("bnd_255_timeout", int'(timeout), 0);
        wave(5, 251);
        n_valid = 0;
        wave(5, 50);
        check("bnd_256_captures", n_valid, 0);
        check("bnd_256_timeout", int'(timeout), 1);
        check("bnd_256_active", int'(active), 1);

        repeat (4) wave(198, 2);
        check("mostly_high_period", got_period, 200);
        check("mostly_high_high", got_high, 198);

        repeat (200) wave($urandom_range(1, 140), $urandom_range(1, 140));
        repeat (300) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
